// File: rtl/pc_sequencer_defs.sv
// Shared opcode, state and width constants for the PC sequencer
// and the decode/link-write logic around it.
package pc_sequencer_defs;

  localparam int PC_WIDTH_DEF = 12;

  localparam logic [5:0] OP_HALT = 6'b010011;
  localparam logic [5:0] OP_JUMP = 6'b010100;
  localparam logic [5:0] OP_BRZ  = 6'b010101;
  localparam logic [5:0] OP_BRNZ = 6'b010110;
  localparam logic [5:0] OP_CALL = 6'b010111;
  localparam logic [5:0] OP_RET  = 6'b011000;

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; pointer counts 0..DEPTH.
// Push on full and pop on empty are ignored here.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_ptr;

  assign top_ptr  = ptr - PW'(1);
  assign pop_data = mem[top_ptr[IW-1:0]];
  assign empty    = (ptr == '0);
  assign full     = (ptr == PW'(DEPTH));

  always_ff @(posedge clock) begin
    if (clear) begin
      ptr <= '0;
    end else if (push && !full) begin
      mem[ptr[IW-1:0]] <= push_data;
      ptr              <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= top_ptr;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: next-PC mux, RUN/HALTED FSM,
// return-address stack and sticky stack error flags.
module pc_sequencer
  import pc_sequencer_defs::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic [5:0]          operation,
  input  logic                condition_zero,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic [PC_WIDTH-1:0] link_address,
  output logic                halted,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  logic [0:0]          state;
  logic [0:0]          state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pop_data;
  logic                push;
  logic                pop;
  logic                empty;
  logic                full;
  logic                set_ovf;
  logic                set_unf;

  logic is_halt;
  logic is_jump;
  logic is_brz;
  logic is_brnz;
  logic is_call;
  logic is_ret;

  assign is_halt = (operation == OP_HALT);
  assign is_jump = (operation == OP_JUMP);
  assign is_brz  = (operation == OP_BRZ);
  assign is_brnz = (operation == OP_BRNZ);
  assign is_call = (operation == OP_CALL);
  assign is_ret  = (operation == OP_RET);

  assign pc_inc          = pc + PC_WIDTH'(1);
  assign program_counter = pc;
  assign link_address    = pc_inc;
  assign halted          = (state == HALTED);

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_stack (
    .clock     (clock),
    .clear     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .empty     (empty),
    .full      (full)
  );

  always_comb begin
    pc_next    = pc;
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (!stall) begin
      if (state == HALTED) begin
        if (resume) begin
          pc_next    = pc_inc;
          state_next = RUN;
        end
      end else begin
        unique case (1'b1)
          is_halt: state_next = HALTED;
          is_jump: pc_next = jump_target;
          is_brz: begin
            pc_next = condition_zero ? jump_target : pc_inc;
          end
          is_brnz: begin
            pc_next = condition_zero ? pc_inc : jump_target;
          end
          is_call: begin
            // jump is taken even when the push is dropped
            pc_next = jump_target;
            push    = !full;
            set_ovf = full;
          end
          is_ret: begin
            if (empty) begin
              pc_next = pc_inc;
              set_unf = 1'b1;
            end else begin
              pc_next = pop_data;
              pop     = 1'b1;
            end
          end
          default: pc_next = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc              <= '0;
      state           <= RUN;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      pc              <= pc_next;
      state           <= state_next;
      stack_overflow  <= stack_overflow | set_ovf;
      stack_underflow <= stack_underflow | set_unf;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + random bench for pc_sequencer against a
// queue-based behavioural model.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [5:0]  operation = 6'd0;
  logic        condition_zero = 1'b0;
  logic [11:0] jump_target = 12'd0;
  logic        resume = 1'b0;
  logic [11:0] program_counter;
  logic [11:0] link_address;
  logic        halted;
  logic        stack_overflow;
  logic        stack_underflow;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  int m_pc = 0;
  bit m_halt = 0;
  bit m_ovf = 0;
  bit m_unf = 0;
  int stk[$];

  pc_sequencer #(
    .PC_WIDTH    (12),
    .STACK_DEPTH (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .operation       (operation),
    .condition_zero  (condition_zero),
    .jump_target     (jump_target),
    .resume          (resume),
    .program_counter (program_counter),
    .link_address    (link_address),
    .halted          (halted),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: next state from the current inputs.
  always @(posedge clock) begin
    if (reset) begin
      started = 1;
      m_pc = 0;
      m_halt = 0;
      m_ovf = 0;
      m_unf = 0;
      stk.delete();
    end else if (!started || stall) begin
    end else if (m_halt) begin
      if (resume) begin
        m_pc = (m_pc + 1) % 4096;
        m_halt = 0;
      end
    end else begin
      case (operation)
        6'h13: m_halt = 1;
        6'h14: m_pc = jump_target;
        6'h15: m_pc = condition_zero ? int'(jump_target)
                                     : (m_pc + 1) % 4096;
        6'h16: m_pc = condition_zero ? (m_pc + 1) % 4096
                                     : int'(jump_target);
        6'h17: begin
          if (stk.size() < 4) stk.push_back((m_pc + 1) % 4096);
          else m_ovf = 1;
          m_pc = jump_target;
        end
        6'h18: begin
          if (stk.size() > 0) m_pc = stk.pop_back();
          else begin
            m_unf = 1;
            m_pc = (m_pc + 1) % 4096;
          end
        end
        default: m_pc = (m_pc + 1) % 4096;
      endcase
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("pc", int'(program_counter), m_pc);
      chk("link", int'(link_address), (m_pc + 1) % 4096);
      chk("halted", int'(halted), int'(m_halt));
      chk("overflow", int'(stack_overflow), int'(m_ovf));
      chk("underflow", int'(stack_underflow), int'(m_unf));
    end
  end

  task automatic tick(input logic [5:0] op,
                      input logic cz = 1'b0,
                      input logic [11:0] tgt = 12'h000,
                      input logic st = 1'b0,
                      input logic rs = 1'b0,
                      input logic rst = 1'b0);
    operation = op;
    condition_zero = cz;
    jump_target = tgt;
    stall = st;
    resume = rs;
    reset = rst;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    @(negedge clock);
    #1;
    tick(6'h00, 0, 0, 0, 0, 1);
    chk("rst_pc", int'(program_counter), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_flags", int'({stack_overflow, stack_underflow}), 0);
    for (int i = 1; i <= 5; i++) begin
      tick(6'h00);
      chk("seq_pc", int'(program_counter), i);
    end

    tick(6'h14, 0, 12'hFFE);
    chk("jmp_ffe", int'(program_counter), 12'hFFE);
    tick(6'h00);
    chk("pc_fff", int'(program_counter), 12'hFFF);
    chk("link_wrap", int'(link_address), 12'h000);
    tick(6'h00);
    chk("pc_wrap", int'(program_counter), 12'h000);

    tick(6'h14, 0, 12'h010);
    tick(6'h15, 1, 12'h200);
    chk("brz_taken", int'(program_counter), 12'h200);
    tick(6'h16, 1, 12'h200);
    chk("brnz_fall", int'(program_counter), 12'h201);
    for (int i = 0; i < 3; i++) begin
      tick(6'h14, 0, 12'h555, 1);
      chk("stall_hold", int'(program_counter), 12'h201);
    end
    tick(6'h15, 0, 12'h700);
    chk("brz_fall", int'(program_counter), 12'h202);

    tick(6'h14, 0, 12'h020);
    tick(6'h17, 0, 12'h100);
    chk("call", int'(program_counter), 12'h100);
    tick(6'h18);
    chk("ret", int'(program_counter), 12'h021);

    tick(6'h17, 0, 12'h100);
    tick(6'h17, 0, 12'h200);
    tick(6'h17, 0, 12'h300);
    tick(6'h17, 0, 12'h400);
    chk("ovf_clear", int'(stack_overflow), 0);
    tick(6'h17, 0, 12'h500);
    chk("ovf_pc", int'(program_counter), 12'h500);
    chk("ovf_set", int'(stack_overflow), 1);
    tick(6'h18);
    chk("ret1", int'(program_counter), 12'h301);
    tick(6'h18);
    chk("ret2", int'(program_counter), 12'h201);
    tick(6'h18);
    chk("ret3", int'(program_counter), 12'h101);
    tick(6'h18);
    chk("ret4", int'(program_counter), 12'h022);
    chk("unf_clear", int'(stack_underflow), 0);
    tick(6'h18);
    chk("unf_pc", int'(program_counter), 12'h023);
    chk("unf_set", int'(stack_underflow), 1);

    tick(6'h14, 0, 12'h030);
    tick(6'h13);
    chk("halt_flag", int'(halted), 1);
    for (int i = 0; i < 10; i++) begin
      tick(6'($urandom), 1'($urandom), 12'($urandom));
      chk("halt_hold", int'(program_counter), 12'h030);
    end
    tick(6'h00, 0, 0, 1, 1);
    chk("res_stall", int'({halted, program_counter}),
        {1'b1, 12'h030});
    tick(6'h00, 0, 0, 0, 1);
    chk("resume_pc", int'(program_counter), 12'h031);
    chk("resume_run", int'(halted), 0);

    tick(6'h17, 0, 12'h080);
    tick(6'h13);
    tick(6'h00, 0, 0, 1, 1, 1);
    chk("rst_h_pc", int'(program_counter), 0);
    chk("rst_h_halt", int'(halted), 0);
    chk("rst_h_flags",
        int'({stack_overflow, stack_underflow}), 0);
    tick(6'h18);
    chk("rst_h_unf", int'(stack_underflow), 1);
    chk("rst_h_pc1", int'(program_counter), 1);

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      int r;
      r = $urandom_range(0, 9);
      op = (r < 3) ? 6'($urandom)
                   : 6'(6'h12 + $urandom_range(0, 6));
      tick(op, 1'($urandom), 12'($urandom),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
